// File: rtl/counter_run_arbiter.sv
// Two-requester arbiter that owns a shared loadable up-counter: grant, load start, run to stop, gap.
// Optional macro ROUND_ROBIN_EN selects round-robin tie-breaking; undefined means req0 has fixed priority.
module counter_run_arbiter #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] stop0,
  input  logic             req1,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] stop1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_base,
  output logic             cnt_ena,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester raises req (level) with start/stop stable; the arbiter answers with a
  // one-cycle gnt when the run is loaded and a one-cycle done when the counter reaches stop. The
  // requester drops req the cycle after done; dropping req earlier aborts the run without done.

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic [WIDTH-1:0] start_l, start_nxt;
  logic [WIDTH-1:0] stop_l, stop_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             any_req;
  logic             winner;
  logic             owner_req;
  logic             at_stop;

  assign any_req   = req0 | req1;
  assign owner_req = owner ? req1 : req0;
  assign at_stop   = (cnt_q == stop_l);
  assign dbg_state = state;

`ifdef ROUND_ROBIN_EN
  // rr_ptr names the requester preferred on the next tie (0 = req0).
  logic rr_ptr, rr_nxt;

  assign winner = req1 & (~req0 | rr_ptr);

  always_comb begin
    rr_nxt = rr_ptr;
    if (state == S_IDLE && any_req) rr_nxt = ~winner;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= 1'b0;
    else       rr_ptr <= rr_nxt;
  end
`else
  assign winner = req1 & ~req0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      start_l <= '0;
      stop_l  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      start_l <= start_nxt;
      stop_l  <= stop_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    start_nxt = start_l;
    stop_nxt  = stop_l;
    gap_nxt   = gap_cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = 1'b0;
    cnt_load  = 1'b0;
    cnt_base  = '0;
    cnt_ena   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          owner_nxt = winner;
          start_nxt = winner ? start1 : start0;
          stop_nxt  = winner ? stop1 : stop0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        gnt0      = ~owner;
        gnt1      = owner;
        cnt_load  = 1'b1;
        cnt_base  = start_l;
        cnt_ena   = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        gap_nxt = '0;
        // An abort takes precedence over reaching stop in the same cycle.
        if (!owner_req) begin
          state_nxt = S_GAP;
        end else if (at_stop) begin
          done0     = ~owner;
          done1     = owner;
          state_nxt = S_GAP;
        end else begin
          cnt_ena = 1'b1;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  a_one_gnt:  assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
  a_one_done: assert property (@(posedge clk) disable iff (reset) !(done0 && done1));
  a_load_run: assert property (@(posedge clk) disable iff (reset) (state == S_LOAD) |=> (state == S_RUN));

endmodule
